nubus_cpu_wbuf: RTL and testbench

Posted-write buffer and request sequencer between a local CPU bus and the `cpu_*` master port of the `nubus` core. Host writes are acknowledged after one cycle and queued in a FIFO, then drained to NuBus one transaction at a time. Host reads stall until the queue is empty, then pass through, so read-after-write ordering always holds. The block sits directly upstream of the `nubus` master port and drives `cpu_valid/cpu_addr/cpu_wdata/cpu_write/cpu_lock`.

---
 rtl/nubus_wbuf_pkg.sv | 20 ++
 rtl/nubus_wbuf_fifo.sv | 51 +++++
 rtl/nubus_cpu_wbuf.sv | 126 ++++++++++++
 tb/tb_nubus_cpu_wbuf.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_wbuf_pkg.sv
// Shared types for the NuBus CPU posted-write buffer: master FSM states, queued entry, NOP strobe.
// No logic; imported by nubus_wbuf_fifo and nubus_cpu_wbuf.
package nubus_wbuf_pkg;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WRITE = 2'd1,
        M_READ  = 2'd2,
        M_GAP   = 2'd3
    } m_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } wbuf_entry_t;

    localparam logic [3:0] STRB_NOP = 4'b0000;

endpackage

// File: rtl/nubus_wbuf_fifo.sv
// Purpose: 2^DEPTH_W-entry queue of posted host writes.
// Latency: an entry pushed this cycle is visible at the head next cycle.
// Backpressure: caller must not push when full nor pop when empty.
module nubus_wbuf_fifo
    import nubus_wbuf_pkg::*;
#(
    parameter int DEPTH_W = 2
) (
    input  logic               nub_clkn,
    input  logic               nub_resetn,
    input  logic               push,
    input  wbuf_entry_t        push_dat,
    input  logic               pop,
    output wbuf_entry_t        head_dat,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W:0]   count
);

    localparam int DEPTH = 1 << DEPTH_W;

    wbuf_entry_t            mem [DEPTH];
    logic [DEPTH_W-1:0]     wr_ptr;
    logic [DEPTH_W-1:0]     rd_ptr;

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge nub_clkn) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = count[DEPTH_W];
    assign empty    = (count == '0);

endmodule

// File: rtl/nubus_cpu_wbuf.sv
// Purpose: posted-write buffer and request sequencer in front of the nubus cpu_* master port (option NUBUS_WBUF_LOCK_EN).
// Latency: writes acked 1 cycle after accept; reads wait for drain, then IDLE + NuBus latency + 1.
// Backpressure: host_ready withheld while the queue is full or a read/locked access is outstanding.
module nubus_cpu_wbuf
    import nubus_wbuf_pkg::*;
#(
    parameter int DEPTH_W = 2
) (
    input  logic               nub_clkn,
    input  logic               nub_resetn,
    input  logic               host_valid,
    input  logic [3:0]         host_write,
    input  logic [31:0]        host_addr,
    input  logic [31:0]        host_wdata,
    input  logic               host_lock,
    output logic               host_ready,
    output logic [31:0]        host_rdata,
    output logic               cpu_valid,
    output logic [31:0]        cpu_addr,
    output logic [31:0]        cpu_wdata,
    output logic [3:0]         cpu_write,
    output logic               cpu_lock,
    input  logic               cpu_ready,
    input  logic [31:0]        cpu_rdata,
    output logic [DEPTH_W:0]   wbuf_count,
    output logic               wbuf_empty
);

    m_state_t       state;
    wbuf_entry_t    push_dat;
    wbuf_entry_t    head_dat;
    logic           fifo_full;
    logic           fifo_empty;
    logic           lock_req;
    logic           push;
    logic           pop;
    logic           direct_req;

`ifdef NUBUS_WBUF_LOCK_EN
    assign lock_req = host_lock;
`else
    logic unused_host_lock;
    assign unused_host_lock = host_lock;
    assign lock_req         = 1'b0;
`endif

    // host_ready high means the current request is already done; never act on it twice.
    assign push       = host_valid && (host_write != STRB_NOP) && !lock_req && !fifo_full && !host_ready;
    assign direct_req = host_valid && ((host_write == STRB_NOP) || lock_req) && !host_ready;
    assign pop        = (state == M_WRITE) && cpu_ready;

    assign push_dat = '{addr: host_addr, wdata: host_wdata, strb: host_write};

    nubus_wbuf_fifo #(
        .DEPTH_W (DEPTH_W)
    ) u_fifo (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .push       (push),
        .push_dat   (push_dat),
        .pop        (pop),
        .head_dat   (head_dat),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (wbuf_count)
    );

    assign wbuf_empty = fifo_empty && (state != M_WRITE);

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state      <= M_IDLE;
            host_ready <= 1'b0;
            host_rdata <= '0;
            cpu_valid  <= 1'b0;
            cpu_addr   <= '0;
            cpu_wdata  <= '0;
            cpu_write  <= STRB_NOP;
            cpu_lock   <= 1'b0;
        end else begin
            host_ready <= push;
            case (state)
                M_IDLE: begin
                    if (!fifo_empty) begin
                        cpu_valid <= 1'b1;
                        cpu_addr  <= head_dat.addr;
                        cpu_wdata <= head_dat.wdata;
                        cpu_write <= head_dat.strb;
                        cpu_lock  <= 1'b0;
                        state     <= M_WRITE;
                    end else if (direct_req) begin
                        // Reads and locked accesses bypass the queue once it has drained.
                        cpu_valid <= 1'b1;
                        cpu_addr  <= host_addr;
                        cpu_wdata <= host_wdata;
                        cpu_write <= lock_req ? host_write : STRB_NOP;
                        cpu_lock  <= lock_req;
                        state     <= M_READ;
                    end
                end
                M_WRITE: begin
                    if (cpu_ready) begin
                        cpu_valid <= 1'b0;
                        state     <= M_GAP;
                    end
                end
                M_READ: begin
                    if (cpu_ready) begin
                        cpu_valid  <= 1'b0;
                        cpu_lock   <= 1'b0;
                        host_rdata <= cpu_rdata;
                        host_ready <= 1'b1;
                        state      <= M_GAP;
                    end
                end
                M_GAP: begin
                    state <= M_IDLE;
                end
                default: begin
                    state <= M_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_cpu_wbuf.sv
// Bench for nubus_cpu_wbuf: directed steps plus random traffic against a NuBus slave model,
// a host-order transaction scoreboard and a byte-lane reference memory.
module tb_nubus_cpu_wbuf;

    localparam int DEPTH_W = 2;

    logic               nub_clkn = 1'b0;
    logic               nub_resetn;
    logic               host_valid;
    logic [3:0]         host_write;
    logic [31:0]        host_addr;
    logic [31:0]        host_wdata;
    logic               host_lock;
    logic               host_ready;
    logic [31:0]        host_rdata;
    logic               cpu_valid;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [3:0]         cpu_write;
    logic               cpu_lock;
    logic               cpu_ready;
    logic [31:0]        cpu_rdata;
    logic [DEPTH_W:0]   wbuf_count;
    logic               wbuf_empty;

    nubus_cpu_wbuf #(.DEPTH_W(DEPTH_W)) dut (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .host_valid (host_valid),
        .host_write (host_write),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_ready (host_ready),
        .host_rdata (host_rdata),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .cpu_lock   (cpu_lock),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .wbuf_count (wbuf_count),
        .wbuf_empty (wbuf_empty)
    );

    always #5 nub_clkn = ~nub_clkn;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        lock;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    txn_t        exp_q[$];
    logic [31:0] ref_mem [bit [29:0]];
    logic [31:0] slv_mem [bit [29:0]];
    int          slave_lat = 1;
    bit          slave_en = 1'b1;
    int          wait_cnt = -1;
    int          wr_end_cyc = 0;
    int          rd_start_cyc = 0;
    int          valid_rises = 0;

    always @(posedge nub_clkn) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // NuBus slave: answers each request after slave_lat cycles and checks it against host order.
    initial begin : slave
        txn_t        e;
        bit [29:0]   k;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        forever begin
            @(negedge nub_clkn);
            if (!nub_resetn) begin
                cpu_ready = 1'b0;
                wait_cnt  = -1;
            end else if (cpu_ready) begin
                cpu_ready = 1'b0;
            end else if (cpu_valid && slave_en) begin
                if (wait_cnt < 0) begin
                    wait_cnt = slave_lat;
                    if (cpu_write == 4'b0000) rd_start_cyc = cyc;
                end
                if (wait_cnt == 0) begin
                    wait_cnt = -1;
                    check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sb_addr", cpu_addr, e.addr);
                        check("sb_strb", 32'(cpu_write), 32'(e.strb));
                        check("sb_lock", 32'(cpu_lock), 32'(e.lock));
                        if (e.strb != 4'b0000) check("sb_wdata", cpu_wdata, e.wdata);
                    end
                    k = cpu_addr[31:2];
                    if (cpu_write != 4'b0000) begin
                        slv_mem[k] = merge(slv_mem.exists(k) ? slv_mem[k] : 32'h0, cpu_wdata, cpu_write);
                        cpu_rdata  = $urandom;
                        wr_end_cyc = cyc;
                    end else begin
                        cpu_rdata = slv_mem.exists(k) ? slv_mem[k] : 32'h0;
                    end
                    cpu_ready = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Request stability while cpu_valid is held, and queue occupancy bound.
    initial begin : monitor
        logic        prev_valid;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        logic [3:0]  prev_write;
        prev_valid = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        prev_write = '0;
        forever begin
            @(negedge nub_clkn);
            if (nub_resetn) begin
                if (cpu_valid && !prev_valid) valid_rises++;
                if (cpu_valid && prev_valid) begin
                    check("stable_addr", cpu_addr, prev_addr);
                    check("stable_wdata", cpu_wdata, prev_wdata);
                    check("stable_write", 32'(cpu_write), 32'(prev_write));
                end
                check("count_bound", 32'(wbuf_count <= (1 << DEPTH_W)), 32'd1);
            end
            prev_valid = cpu_valid;
            prev_addr  = cpu_addr;
            prev_wdata = cpu_wdata;
            prev_write = cpu_write;
        end
    end

    // Drives a request at the current negedge and records it in the reference model.
    task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic lk);
        txn_t t;
        bit [29:0] k;
        host_valid = 1'b1;
        host_addr  = a;
        host_wdata = d;
        host_write = s;
        host_lock  = lk;
        t.addr  = a;
        t.wdata = d;
        t.strb  = s;
`ifdef NUBUS_WBUF_LOCK_EN
        t.lock  = lk;
`else
        t.lock  = 1'b0;
`endif
        exp_q.push_back(t);
        k = a[31:2];
        if (s != 4'b0000) ref_mem[k] = merge(ref_mem.exists(k) ? ref_mem[k] : 32'h0, d, s);
    endtask

    task automatic wait_ack(output int lat, output logic [31:0] rd);
        lat = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge nub_clkn);
            if (host_ready) begin
                lat = i;
                break;
            end
        end
        host_valid = 1'b0;
        host_lock  = 1'b0;
        rd = host_rdata;
        check("ack_timeout", 32'(lat != 0), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic lk,
                            output int lat);
        logic [31:0] rd;
        start_req(a, d, s, lk);
        wait_ack(lat, rd);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] rd);
        int lat;
        bit [29:0] k;
        logic [31:0] exp;
        k = a[31:2];
        exp = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        start_req(a, $urandom, 4'b0000, 1'b0);
        wait_ack(lat, rd);
        check("read_data", rd, exp);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge nub_clkn);
            if (wbuf_empty && !cpu_valid && !cpu_ready && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    initial begin : main
        int          lat;
        int          ack_cyc;
        int          rises0;
        bit          any_ready;
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;

        nub_resetn = 1'b0;
        host_valid = 1'b0;
        host_write = '0;
        host_addr  = '0;
        host_wdata = '0;
        host_lock  = 1'b0;
        repeat (3) @(negedge nub_clkn);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_host_rdata", host_rdata, 32'h0);
        check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        check("rst_cpu_addr", cpu_addr, 32'h0);
        check("rst_cpu_wdata", cpu_wdata, 32'h0);
        check("rst_cpu_write", 32'(cpu_write), 32'd0);
        check("rst_cpu_lock", 32'(cpu_lock), 32'd0);
        check("rst_wbuf_count", 32'(wbuf_count), 32'd0);
        check("rst_wbuf_empty", 32'(wbuf_empty), 32'd1);
        nub_resetn = 1'b1;
        @(negedge nub_clkn);

        // Single word write: ack next cycle, master request the cycle after.
        slave_lat = 2;
        start_req(32'hF900_0000, 32'h8765_4321, 4'b1111, 1'b0);
        @(negedge nub_clkn);
        check("sw_ack", 32'(host_ready), 32'd1);
        check("sw_cpu_valid_early", 32'(cpu_valid), 32'd0);
        check("sw_count", 32'(wbuf_count), 32'd1);
        host_valid = 1'b0;
        @(negedge nub_clkn);
        check("sw_ack_pulse", 32'(host_ready), 32'd0);
        check("sw_cpu_valid", 32'(cpu_valid), 32'd1);
        check("sw_cpu_addr", cpu_addr, 32'hF900_0000);
        check("sw_cpu_wdata", cpu_wdata, 32'h8765_4321);
        check("sw_cpu_write", 32'(cpu_write), 32'hF);
        wait_idle();

        // Fill the queue with the slave stalled; the fifth write waits for a pop.
        slave_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_write(32'h0000_0100 + 32'(i * 4), $urandom, 4'b1111, 1'b0, lat);
            check("fill_ack_lat", 32'(lat), (i == 0) ? 32'd1 : 32'd2);
        end
        check("fill_count", 32'(wbuf_count), 32'd4);
        check("fill_not_empty", 32'(wbuf_empty), 32'd0);
        start_req(32'h0000_0110, 32'hCAFE_F00D, 4'b1111, 1'b0);
        any_ready = 1'b0;
        repeat (6) begin
            @(negedge nub_clkn);
            any_ready |= host_ready;
        end
        check("full_held", 32'(any_ready), 32'd0);
        check("full_count", 32'(wbuf_count), 32'd4);
        slave_lat = 0;
        slave_en  = 1'b1;
        wait_ack(lat, rd);
        ack_cyc = cyc;
        check("full_ack_after_pop", 32'(ack_cyc - wr_end_cyc), 32'd2);
        check("full_count_after", 32'(wbuf_count), 32'd4);
        wait_idle();

        // Read after write: read waits for write completion plus GAP and IDLE.
        slave_lat = 3;
        do_write(32'h0000_4000, 32'h8765_4321, 4'b1111, 1'b0, lat);
        check("raw_wr_lat", 32'(lat), 32'd1);
        do_read(32'h0000_4000, rd);
        check("raw_rdata", rd, 32'h8765_4321);
        check("raw_order", 32'(rd_start_cyc - wr_end_cyc), 32'd3);
        wait_idle();

        // Byte lane passthrough.
        slave_lat = 1;
        do_write(32'hF900_0014, 32'h8765_4321, 4'b0100, 1'b0, lat);
        @(negedge nub_clkn);
        check("lane_valid", 32'(cpu_valid), 32'd1);
        check("lane_strb", 32'(cpu_write), 32'h4);
        do_read(32'hF900_0014, rd);
        check("lane_rdata", rd, 32'h0065_0000);
        wait_idle();

        // Random mix of writes and reads over a small address window.
        for (int n = 0; n < 60; n++) begin
            slave_lat = $urandom_range(0, 3);
            a = 32'h0000_0200 + 32'($urandom_range(0, 3) * 4);
            if ($urandom_range(0, 9) < 6) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(1, 15)), 1'b0, lat);
            end else begin
                do_read(a, rd);
            end
            repeat ($urandom_range(0, 2)) @(negedge nub_clkn);
        end
        wait_idle();

        // Reset with three writes queued: everything is discarded at once.
        slave_en = 1'b0;
        for (int i = 0; i < 3; i++) do_write(32'h0000_3000 + 32'(i * 4), $urandom, 4'b1111, 1'b0, lat);
        check("rq_count", 32'(wbuf_count), 32'd3);
        nub_resetn = 1'b0;
        #1;
        check("rq_cpu_valid", 32'(cpu_valid), 32'd0);
        check("rq_count_clr", 32'(wbuf_count), 32'd0);
        check("rq_empty", 32'(wbuf_empty), 32'd1);
        check("rq_host_ready", 32'(host_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge nub_clkn);
        nub_resetn = 1'b1;
        slave_en   = 1'b1;
        rises0     = valid_rises;
        repeat (10) @(negedge nub_clkn);
        check("rq_no_stale", 32'(valid_rises - rises0), 32'd0);
        check("rq_cpu_valid_after", 32'(cpu_valid), 32'd0);

        // Locked write.
        slave_lat = 2;
`ifdef NUBUS_WBUF_LOCK_EN
        begin
            bit lock_seen;
            bit cnt_bad;
            do_write(32'h0000_5000, 32'h1111_2222, 4'b1111, 1'b0, lat);
            start_req(32'h0000_5004, 32'h3333_4444, 4'b1111, 1'b1);
            lock_seen = 1'b0;
            cnt_bad   = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge nub_clkn);
                if (cpu_valid && cpu_lock) begin
                    lock_seen = 1'b1;
                    if (wbuf_count != 0) cnt_bad = 1'b1;
                end
                if (host_ready) break;
            end
            check("lock_ack", 32'(host_ready), 32'd1);
            host_valid = 1'b0;
            host_lock  = 1'b0;
            check("lock_issued", 32'(lock_seen), 32'd1);
            check("lock_not_queued", 32'(cnt_bad), 32'd0);
        end
`else
        do_write(32'h0000_5004, 32'h3333_4444, 4'b1111, 1'b1, lat);
        check("nolock_lat", 32'(lat), 32'd1);
        check("nolock_count", 32'(wbuf_count), 32'd1);
        @(negedge nub_clkn);
        check("nolock_valid", 32'(cpu_valid), 32'd1);
        check("nolock_cpu_lock", 32'(cpu_lock), 32'd0);
`endif
        wait_idle();
        do_read(32'h0000_5004, rd);
        check("lock_data", rd, 32'h3333_4444);
        wait_idle();

        check("end_sb_empty", 32'(exp_q.size()), 32'd0);
        check("end_count", 32'(wbuf_count), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
